// File: rtl/spi_sclk_gen.sv
// SPI master SCLK / chip-select generator with one-cycle rx/tx edge strobes.
// Sequence per transfer: LEAD (CS setup) -> XFER (2N SCLK edges) -> TRAIL (CS hold).
module spi_sclk_gen #(
    parameter int DIV_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             start_i,
    input  logic [15:0]      bits_len_i,
    input  logic [DIV_W-1:0] clk_div_i,
    input  logic             cpol_i,
    input  logic             cpha_i,
    input  logic             hold_i,
    output logic             sclk_o,
    output logic             cs_n_o,
    output logic             rx_edge_o,
    output logic             tx_edge_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LEAD  = 2'd1;
    localparam logic [1:0] S_XFER  = 2'd2;
    localparam logic [1:0] S_TRAIL = 2'd3;

    logic [1:0]       state;
    logic [DIV_W-1:0] div_cnt;
    logic [16:0]      edge_cnt;
    logic [15:0]      bits_q;
    logic [DIV_W-1:0] div_q;
    logic             cpol_q;
    logic             cpha_q;

    logic             tc;
    logic [16:0]      edge_nxt;
    logic             edge_lead;
    logic             edge_last;
    logic             rx_hit;
    logic             tx_hit;

    // Decode the edge about to happen: leading/trailing, last, and which strobe it owns.
    always_comb begin
        tc        = (div_cnt == div_q);
        edge_nxt  = edge_cnt + 17'd1;
        edge_lead = edge_nxt[0];
        edge_last = (edge_nxt == {bits_q, 1'b0});
        rx_hit    = cpha_q ? ~edge_lead : edge_lead;
        tx_hit    = cpha_q ? edge_lead : (~edge_lead & ~edge_last);
    end

    // Main sequencer: the LEAD terminal count doubles as SCLK edge 1, so edge k
    // lands at t0 + k*(D+1) and TRAIL ends at t0 + (2N+1)*(D+1).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= S_IDLE;
            div_cnt   <= '0;
            edge_cnt  <= '0;
            bits_q    <= '0;
            div_q     <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            sclk_o    <= 1'b0;
            cs_n_o    <= 1'b1;
            rx_edge_o <= 1'b0;
            tx_edge_o <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            rx_edge_o <= 1'b0;
            tx_edge_o <= 1'b0;
            done_o    <= 1'b0;
            if (!en_i) begin
                // Abort: drop straight back to idle without a done pulse.
                state   <= S_IDLE;
                div_cnt <= '0;
                cs_n_o  <= 1'b1;
                busy_o  <= 1'b0;
                sclk_o  <= cpol_i;
            end else begin
                case (state)
                    S_IDLE: begin
                        sclk_o <= cpol_i;
                        if (start_i && bits_len_i != 16'd0) begin
                            state    <= S_LEAD;
                            div_cnt  <= '0;
                            edge_cnt <= '0;
                            bits_q   <= bits_len_i;
                            div_q    <= clk_div_i;
                            cpol_q   <= cpol_i;
                            cpha_q   <= cpha_i;
                            cs_n_o   <= 1'b0;
                            busy_o   <= 1'b1;
                        end
                    end
                    S_LEAD: begin
                        if (tc) begin
                            state     <= S_XFER;
                            div_cnt   <= '0;
                            edge_cnt  <= edge_nxt;
                            sclk_o    <= ~sclk_o;
                            rx_edge_o <= rx_hit;
                            tx_edge_o <= tx_hit;
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                    S_XFER: begin
                        if (!hold_i) begin
                            if (tc) begin
                                div_cnt   <= '0;
                                edge_cnt  <= edge_nxt;
                                sclk_o    <= ~sclk_o;
                                rx_edge_o <= rx_hit;
                                tx_edge_o <= tx_hit;
                                if (edge_last) state <= S_TRAIL;
                            end else begin
                                div_cnt <= div_cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        if (tc) begin
                            state   <= S_IDLE;
                            div_cnt <= '0;
                            sclk_o  <= cpol_q;
                            cs_n_o  <= 1'b1;
                            busy_o  <= 1'b0;
                            done_o  <= 1'b1;
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule
